// File: rtl/tse_reg_bridge.sv
// tse_reg_bridge: turns single-cycle register read/write pulses from the TSE
// configuration sequencer into held Avalon-MM transfers on the MAC control
// slave. It honours waitrequest, captures read data and aborts stalled
// transfers after TIMEOUT_CYCLES. All outputs are registered.
module tse_reg_bridge #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RESET_HOLD     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_rd,
    input  logic              req_wr,
    output logic              req_busy,
    output logic [DATA_W-1:0] req_rdata,
    output logic              req_rdata_valid,
    output logic              req_error,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic [DATA_W-1:0] avm_writedata,
    output logic              avm_write,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    localparam int HOLD_W  = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_IDLE,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_DONE,
        S_ERROR
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic                w_hold_done;
    logic                w_timeout;
    logic                w_accept_wr;
    logic                w_accept_rd;
    logic                w_rd_complete;

    logic                r_busy;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rdata_valid;
    logic                r_error;
    logic [7:0]          r_err_cnt;
    logic [ADDR_W-1:0]   r_avm_address;
    logic [DATA_W-1:0]   r_avm_writedata;
    logic                r_avm_write;
    logic                r_avm_read;

    assign w_hold_done   = (r_hold_cnt == HOLD_W'(RESET_HOLD - 1));
    assign w_timeout     = (r_stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));
    assign w_rd_complete = (r_state == S_RD_ISSUE) && !avm_waitrequest;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_HOLD;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode and request acceptance.
    always_comb begin
        w_state_nxt = r_state;
        w_accept_wr = 1'b0;
        w_accept_rd = 1'b0;
        case (r_state)
            S_HOLD: begin
                if (w_hold_done) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (req_wr && req_rd) begin
                    w_state_nxt = S_ERROR;
                end else if (req_wr) begin
                    w_accept_wr = 1'b1;
                    w_state_nxt = S_WR_ISSUE;
                end else if (req_rd) begin
                    w_accept_rd = 1'b1;
                    w_state_nxt = S_RD_ISSUE;
                end
            end
            S_WR_ISSUE: begin
                if (!avm_waitrequest) w_state_nxt = S_IDLE;
                else if (w_timeout)   w_state_nxt = S_ERROR;
            end
            S_RD_ISSUE: begin
                if (!avm_waitrequest) w_state_nxt = S_RD_DONE;
                else if (w_timeout)   w_state_nxt = S_ERROR;
            end
            S_RD_DONE: w_state_nxt = S_IDLE;
            S_ERROR:   w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_HOLD;
        endcase
    end

    // Post-reset hold counter and per-transfer stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_state == S_HOLD && !w_hold_done) r_hold_cnt <= r_hold_cnt + 1'b1;
            // IDLE always precedes an ISSUE state, so clearing here clears on entry.
            if (r_state == S_IDLE)
                r_stall_cnt <= '0;
            else if ((r_state == S_WR_ISSUE || r_state == S_RD_ISSUE) && avm_waitrequest)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Strobes and status flags registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy        <= 1'b1;
            r_avm_write   <= 1'b0;
            r_avm_read    <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_error       <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_busy        <= (w_state_nxt != S_IDLE);
            r_avm_write   <= (w_state_nxt == S_WR_ISSUE);
            r_avm_read    <= (w_state_nxt == S_RD_ISSUE);
            r_rdata_valid <= (w_state_nxt == S_RD_DONE);
            r_error       <= (w_state_nxt == S_ERROR);
            if (w_state_nxt == S_ERROR && r_err_cnt != 8'hFF)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    // Address/data latches and read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_avm_address   <= '0;
            r_avm_writedata <= '0;
            r_rdata         <= '0;
        end else begin
            if (w_accept_wr || w_accept_rd) r_avm_address <= req_addr;
            if (w_accept_wr)                r_avm_writedata <= req_wdata;
            if (w_rd_complete)              r_rdata <= avm_readdata;
        end
    end

    assign req_busy        = r_busy;
    assign req_rdata       = r_rdata;
    assign req_rdata_valid = r_rdata_valid;
    assign req_error       = r_error;
    assign err_count       = r_err_cnt;
    assign avm_address     = r_avm_address;
    assign avm_writedata   = r_avm_writedata;
    assign avm_write       = r_avm_write;
    assign avm_read        = r_avm_read;

endmodule

// File: tb/tb_tse_reg_bridge.sv
// Scoreboard bench for tse_reg_bridge: stimulus pushes expected events,
// a monitor pops and compares them when the DUT presents them.
module tb_tse_reg_bridge;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int T  = 8;
    localparam int RH = 16;

    localparam int EV_WR  = 0;
    localparam int EV_RDX = 1;
    localparam int EV_RDV = 2;
    localparam int EV_ERR = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_rd;
    logic          req_wr;
    logic          req_busy;
    logic [DW-1:0] req_rdata;
    logic          req_rdata_valid;
    logic          req_error;
    logic [7:0]    err_count;
    logic [AW-1:0] avm_address;
    logic [DW-1:0] avm_writedata;
    logic          avm_write;
    logic          avm_read;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    int   model_err   = 0;
    logic [31:0] model_rdata = '0;

    tse_reg_bridge #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(T),
        .RESET_HOLD(RH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_rd(req_rd),
        .req_wr(req_wr),
        .req_busy(req_busy),
        .req_rdata(req_rdata),
        .req_rdata_valid(req_rdata_valid),
        .req_error(req_error),
        .err_count(err_count),
        .avm_address(avm_address),
        .avm_writedata(avm_writedata),
        .avm_write(avm_write),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input logic [31:0] a, input logic [31:0] d, input string nm);
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected event addr 0x%0h data 0x%0h, required none", nm, a, d);
        end else begin
            e = q.pop_front();
            check({nm, "_kind"}, 64'(kind), 64'(e.kind));
            if (kind == EV_WR || kind == EV_RDX) check({nm, "_addr"}, 64'(a), 64'(e.addr));
            if (kind != EV_RDX) check({nm, "_data"}, 64'(d), 64'(e.data));
        end
    endtask

    // Monitor: samples just after the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                if (avm_write && !avm_waitrequest) pop_check(EV_WR, 32'(avm_address), avm_writedata, "wr_xfer");
                if (avm_read && !avm_waitrequest)  pop_check(EV_RDX, 32'(avm_address), '0, "rd_xfer");
                if (req_rdata_valid)               pop_check(EV_RDV, '0, req_rdata, "rd_valid");
                if (req_error)                     pop_check(EV_ERR, '0, 32'(err_count), "error");
            end
        end
    end

    // Watchdog.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected events pending", q.size());
        $fatal(1, "watchdog");
    end

    // Called right after rst is released at a falling edge.
    task automatic check_hold(input bit pulse_wr);
        for (int c = 1; c <= RH; c++) begin
            if (pulse_wr && c == 5) begin
                req_wr    = 1'b1;
                req_addr  = 8'h55;
                req_wdata = 32'hDEAD_BEEF;
            end else begin
                req_wr = 1'b0;
            end
            @(posedge clk);
            #1;
            check($sformatf("hold_busy_c%0d", c), 64'(req_busy), 64'(c < RH));
            check($sformatf("hold_nowrite_c%0d", c), 64'(avm_write), 64'd0);
        end
        req_wr = 1'b0;
        @(negedge clk);
    endtask

    // kind: 0 write, 1 read, 2 read+write together. s: waitrequest stall cycles.
    task automatic do_req(input int kind, input logic [7:0] a, input logic [31:0] d, input int s);
        int k;
        int busy_cyc;
        int strobe_cyc;
        int exp_busy;
        int exp_strobe;
        bit timed_out;
        k = 0;
        while (req_busy && k < 4 * T) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_req", 64'(req_busy), 64'd0);
        timed_out = (kind != 2) && (s >= T);
        // Reference model: outcome of one request from the protocol rules.
        if (kind == 2 || timed_out) begin
            model_err = (model_err == 255) ? 255 : model_err + 1;
            push(EV_ERR, '0, 32'(model_err));
            exp_busy   = (kind == 2) ? 1 : T + 1;
            exp_strobe = (kind == 2) ? 0 : T;
        end else if (kind == 0) begin
            push(EV_WR, 32'(a), d);
            exp_busy   = s + 1;
            exp_strobe = s + 1;
        end else begin
            push(EV_RDX, 32'(a), '0);
            push(EV_RDV, '0, d);
            model_rdata = d;
            exp_busy   = s + 2;
            exp_strobe = s + 1;
        end
        req_addr        = a;
        req_wdata       = d;
        req_wr          = (kind != 1);
        req_rd          = (kind != 0);
        avm_waitrequest = (s > 0);
        avm_readdata    = (s > 0) ? $urandom : d;
        @(negedge clk);
        req_wr    = 1'b0;
        req_rd    = 1'b0;
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        busy_cyc   = 0;
        strobe_cyc = 0;
        while (req_busy && busy_cyc < 2 * T + 8) begin
            if (avm_write || avm_read) begin
                strobe_cyc++;
                avm_waitrequest = (strobe_cyc <= s);
                avm_readdata    = (strobe_cyc <= s) ? $urandom : d;
                if (strobe_cyc == 1 || strobe_cyc == s + 1) begin
                    check("strobe_kind", 64'({avm_write, avm_read}), (kind == 0) ? 64'd2 : 64'd1);
                    check("strobe_addr", 64'(avm_address), 64'(a));
                    if (kind == 0) check("strobe_wdata", 64'(avm_writedata), 64'(d));
                end
            end else begin
                avm_waitrequest = 1'b0;
            end
            busy_cyc++;
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        check($sformatf("busy_cycles_k%0d_s%0d", kind, s), 64'(busy_cyc), 64'(exp_busy));
        check($sformatf("strobe_cycles_k%0d_s%0d", kind, s), 64'(strobe_cyc), 64'(exp_strobe));
        if (kind == 1) check("rdata_held", 64'(req_rdata), 64'(model_rdata));
    endtask

    initial begin
        rst             = 1'b0;
        req_addr        = '0;
        req_wdata       = '0;
        req_rd          = 1'b0;
        req_wr          = 1'b0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(req_busy), 64'd1);
        check("rst_strobes", 64'({avm_write, avm_read, req_rdata_valid, req_error}), 64'd0);
        check("rst_errcnt", 64'(err_count), 64'd0);
        check("rst_rdata", 64'(req_rdata), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        rst = 1'b1;
        check_hold(1'b1);

        do_req(0, 8'h03, 32'h1723_1C00, 0);
        do_req(1, 8'h02, 32'h0080_2220, 3);
        do_req(0, 8'h11, 32'hCAFE_0001, 20);
        check("errcnt_after_timeout", 64'(err_count), 64'd1);
        do_req(0, 8'h12, 32'hCAFE_0002, 0);
        do_req(2, 8'h13, 32'hCAFE_0003, 0);
        check("errcnt_after_both", 64'(err_count), 64'd2);
        do_req(1, 8'h20, 32'h1234_5678, T - 1);
        do_req(1, 8'h21, 32'h8765_4321, T);
        do_req(0, 8'h22, 32'h0000_00FF, T - 1);

        for (int i = 0; i < 60; i++) begin
            int r;
            int kind;
            int s;
            r    = $urandom_range(9, 0);
            kind = (r < 5) ? 0 : (r < 9) ? 1 : 2;
            s    = ($urandom_range(3, 0) == 0) ? $urandom_range(12, 0) : $urandom_range(3, 0);
            do_req(kind, 8'($urandom), $urandom, s);
        end

        // Reset in the middle of a stalled read.
        while (req_busy) @(negedge clk);
        req_addr        = 8'h21;
        req_rd          = 1'b1;
        avm_waitrequest = 1'b1;
        @(negedge clk);
        req_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_read_high", 64'(avm_read), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_read_drop", 64'(avm_read), 64'd0);
        check("midrst_busy", 64'(req_busy), 64'd1);
        check("midrst_no_pulses", 64'({req_rdata_valid, req_error}), 64'd0);
        repeat (2) @(negedge clk);
        avm_waitrequest = 1'b0;
        model_err   = 0;
        model_rdata = '0;
        rst = 1'b1;
        check_hold(1'b0);
        check("midrst_errcnt", 64'(err_count), 64'd0);
        check("midrst_rdata", 64'(req_rdata), 64'd0);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) do_req(2, 8'($urandom), $urandom, 0);
        check("errcnt_saturated", 64'(err_count), 64'd255);
        do_req(0, 8'h7F, 32'hA5A5_5A5A, 1);
        do_req(1, 8'h40, 32'h0BAD_F00D, 2);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tse_reg_bridge.md
Name: tse_reg_bridge

Overview:
Sits between the TSE MAC configuration sequencer and the MAC's Avalon-MM control slave. Accepts single-cycle register read/write pulses from the sequencer and converts them into held Avalon-MM transfers that respect waitrequest. Captures read data, reports busy back to the sequencer, and aborts hung transfers with a timeout.

Parameters:
ADDR_W, 8, register address width (TSE word address)
DATA_W, 32, register data width
TIMEOUT_CYCLES, 1024, max cycles a transfer may stall on waitrequest before abort (>=2)
RESET_HOLD, 16, cycles req_busy is held high after reset release (>=1)

Ports:
clk  in  1  single clock domain
rst  in  1  asynchronous, active-low reset
req_addr  in  ADDR_W  sequencer register address
req_wdata  in  DATA_W  sequencer write data
req_rd  in  1  read request, one-cycle pulse
req_wr  in  1  write request, one-cycle pulse
req_busy  out  1  bridge cannot accept a request
req_rdata  out  DATA_W  last completed read data
req_rdata_valid  out  1  one-cycle pulse, req_rdata updated
req_error  out  1  one-cycle pulse: timeout or illegal request
err_count  out  8  saturating count of req_error pulses
avm_address  out  ADDR_W  to MAC control port
avm_writedata  out  DATA_W  to MAC
avm_write  out  1  to MAC
avm_read  out  1  to MAC
avm_readdata  in  DATA_W  from MAC
avm_waitrequest  in  1  from MAC

Behaviour:
- Reset (rst low, asynchronous): state HOLD, hold counter 0, all outputs 0 except req_busy=1; avm_read/avm_write drop immediately even mid-transfer; no completion or error reported for the aborted transfer.
- All outputs registered. req_busy=1 in every state except IDLE.
- States: HOLD, IDLE, WR_ISSUE, RD_ISSUE, RD_DONE, ERROR.
- HOLD: count RESET_HOLD cycles after rst deasserts, then IDLE. Requests during HOLD are ignored without error.
- IDLE: sample on a clk edge with req_busy=0:
  - req_wr only: latch addr/wdata into avm_address/avm_writedata; go WR_ISSUE.
  - req_rd only: latch addr; go RD_ISSUE.
  - req_rd and req_wr together: no transfer; go ERROR.
- Requests while req_busy=1: silently dropped. The sequencer obeys busy.
- WR_ISSUE / RD_ISSUE: avm_write (or avm_read) held high with address/data stable every cycle in the state.
  - Transfer completes at the first edge where avm_waitrequest=0.
  - Write completion: go IDLE.
  - Read completion: capture avm_readdata into req_rdata; go RD_DONE.
- RD_DONE: req_rdata_valid=1 for exactly one cycle; go IDLE. req_rdata holds its value until the next read completes.
- Timeout: a stall counter clears on entry to an ISSUE state and increments on each edge with waitrequest=1. If waitrequest is still 1 at the edge where the counter equals TIMEOUT_CYCLES-1, go ERROR.
  - Strobes are low from the first ERROR cycle.
  - For a timed-out read, req_rdata is not updated.
- ERROR: req_error=1 for one cycle; err_count increments, saturating at 255; go IDLE.
- Minimum latency:
  - Write, waitrequest low: request edge T0, avm_write high cycle T0+1, IDLE at T0+2; req_busy high 1 cycle.
  - Read, waitrequest low: busy 2 cycles, valid at T0+2.
- Only one transfer is outstanding at a time. No pipelining or bursts.

Test Plan:
- Reset release, RESET_HOLD=16 -> req_busy=1 for 16 cycles then 0; req_wr pulsed at cycle 5 produces no avm_write.
- req_wr addr=0x03, data=0x17231C00, waitrequest low -> avm_write high exactly 1 cycle with address 0x03, writedata 0x17231C00; req_busy high 1 cycle.
- req_rd addr=0x02, waitrequest high 3 cycles then low with readdata=0x0080_2220 -> avm_read high 4 cycles, address stable; req_rdata=0x0080_2220, req_rdata_valid one pulse.
- TIMEOUT_CYCLES=8, write with waitrequest stuck high -> avm_write high 8 cycles then low; req_error one pulse; err_count=1; next request accepted normally.
- req_rd and req_wr in the same cycle -> no avm strobe; req_error pulse; err_count increments.
- rst low during a stalled read -> avm_read drops the same cycle; no req_rdata_valid or req_error pulse; HOLD sequence restarts.
